// File: rtl/add8_pkg.sv
// Shared types, saturation constants and the saturating add8 reference function.
// Used by add8_arb; the ADD8_ARB_STATS_EN build also uses STAT_W.
package add8_pkg;

    localparam logic [7:0] SAT_SPOS = 8'h7F;
    localparam logic [7:0] SAT_SNEG = 8'h80;
    localparam logic [7:0] SAT_U    = 8'hFF;
    localparam int         STAT_W   = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    typedef struct packed {
        logic [3:0] src0;
        logic [3:0] src1;
        logic [3:0] src2;
        logic [2:0] sign;
    } add8_req_t;

    // Returns {sat, result[7:0]}; bit-exact with the add8_comb cell.
    function automatic logic [8:0] add8_sat(input add8_req_t r);
        logic       is_signed;
        logic [7:0] a;
        logic [8:0] a9;
        logic [8:0] b9;
        logic [8:0] sum;
        logic [8:0] res;
        is_signed = |r.sign;
        a         = {r.src1, r.src0};
        a9        = is_signed ? {a[7], a} : {1'b0, a};
        b9        = is_signed ? {{5{r.src2[3]}}, r.src2} : {5'b0, r.src2};
        sum       = a9 + b9;
        if (is_signed) begin
            case (sum[8:7])
                2'b10:   res = {1'b1, SAT_SNEG};
                2'b01:   res = {1'b1, SAT_SPOS};
                default: res = {1'b0, sum[7:0]};
            endcase
        end else begin
            res = sum[8] ? {1'b1, SAT_U} : {1'b0, sum[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/add8_arb_rr.sv
// Round-robin one-hot arbiter with its own rotating pointer.
// The pointer moves past the winner only when a grant is actually issued.
module rr_arb_onehot #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic          found;

    // Scan upward from the pointer with wrap; first valid requester wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (advance && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);
        end
    end

endmodule

// File: rtl/add8_arb.sv
// Round-robin arbiter sharing one saturating add8 datapath among NREQ requesters.
// Optional statistics counters are enabled with the ADD8_ARB_STATS_EN macro.
module add8_arb
    import add8_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_src0,
    input  logic [4*NREQ-1:0] req_src1,
    input  logic [4*NREQ-1:0] req_src2,
    input  logic [3*NREQ-1:0] req_sign,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [3:0]        rsp_dst0,
    output logic [3:0]        rsp_dst1,
    output logic              rsp_sat
`ifdef ADD8_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_sat_cnt,
    output logic [STAT_W-1:0] stat_op_cnt
`endif
);

    out_state_t      state;
    logic            can_issue;
    logic            advance;
    logic            granted;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    add8_req_t       sel;
    logic [8:0]      res;

    // A held result blocks new grants until downstream takes it.
    assign can_issue = (state == EMPTY) || rsp_ready;
    assign advance   = can_issue && !rst;
    assign granted   = |grant;
    assign req_ready = grant;
    assign rsp_valid = (state == FULL);

    rr_arb_onehot #(
        .N  (NREQ),
        .IW (IDW)
    ) u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .advance  (advance),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel.src0 = req_src0[4*i +: 4];
                sel.src1 = req_src1[4*i +: 4];
                sel.src2 = req_src2[4*i +: 4];
                sel.sign = req_sign[3*i +: 3];
            end
        end
    end

    assign res = add8_sat(sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            rsp_id   <= '0;
            rsp_dst0 <= '0;
            rsp_dst1 <= '0;
            rsp_sat  <= 1'b0;
        end else if (can_issue) begin
            if (granted) begin
                state    <= FULL;
                rsp_id   <= grant_id;
                rsp_dst0 <= res[3:0];
                rsp_dst1 <= res[7:4];
                rsp_sat  <= res[8];
            end else begin
                state    <= EMPTY;
            end
        end
    end

`ifdef ADD8_ARB_STATS_EN
    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_sat_cnt <= '0;
            stat_op_cnt  <= '0;
        end else if (granted) begin
            if (stat_op_cnt != '1)
                stat_op_cnt <= stat_op_cnt + STAT_W'(1);
            if (res[8] && stat_sat_cnt != '1)
                stat_sat_cnt <= stat_sat_cnt + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_add8_arb.sv
// Directed self-checking bench for add8_arb (NREQ=4).
// Exercises the ADD8_ARB_STATS_EN counters when that macro is defined.
module tb_add8_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_src0;
    logic [15:0] req_src1;
    logic [15:0] req_src2;
    logic [11:0] req_sign;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_dst0;
    logic [3:0]  rsp_dst1;
    logic        rsp_sat;
`ifdef ADD8_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_sat_cnt;
    logic [15:0] stat_op_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    add8_arb #(.NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src0  (req_src0),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .req_sign  (req_sign),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_dst0  (rsp_dst0),
        .rsp_dst1  (rsp_dst1),
        .rsp_sat   (rsp_sat)
`ifdef ADD8_ARB_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_sat_cnt (stat_sat_cnt),
        .stat_op_cnt  (stat_op_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] s1, input logic [3:0] s0,
                           input logic [3:0] s2, input logic [2:0] sg);
        req_src1[4*i +: 4] = s1;
        req_src0[4*i +: 4] = s0;
        req_src2[4*i +: 4] = s2;
        req_sign[3*i +: 3] = sg;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
        req_src0 = '0; req_src1 = '0; req_src2 = '0; req_sign = '0;
`ifdef ADD8_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        step(); step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid: got %0b expected 0", rsp_valid); end
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_id: got %0d expected 0", rsp_id); end
        n_checks++; if ({rsp_dst1, rsp_dst0, rsp_sat} !== 9'd0) begin n_fail++; $display("[TB] FAIL rst_data: got %h expected 000", {rsp_dst1, rsp_dst0, rsp_sat}); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_ready: got %b expected 0000", req_ready); end
`ifdef ADD8_ARB_STATS_EN
        n_checks++; if ({stat_sat_cnt, stat_op_cnt} !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_stats: got %h expected 0", {stat_sat_cnt, stat_op_cnt}); end
`endif
        req_valid = 4'b0000;
        rst = 1'b0;
        step();
    endtask

    task automatic test_arith();
        logic [11:0] ops [7] = '{12'h123, 12'hFF1, 12'h7F1, 12'h80F, 12'h05E, 12'hF0F, 12'h108};
        logic [2:0]  sgn [7] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b010, 3'b000, 3'b001};
        logic [8:0]  expv[7] = '{9'h015, 9'h1FF, 9'h17F, 9'h180, 9'h003, 9'h0FF, 9'h008};
        logic [11:0] op;
        rsp_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            op = ops[v];
            set_req(0, op[11:8], op[7:4], op[3:0], sgn[v]);
            req_valid = 4'b0001;
            #1;
            n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL arith_ready[%0d]: got %b expected 0001", v, req_ready); end
            step();
            n_checks++; if ({rsp_valid, rsp_id} !== 3'b100) begin n_fail++; $display("[TB] FAIL arith_vid[%0d]: got %b expected 100", v, {rsp_valid, rsp_id}); end
            n_checks++; if ({rsp_sat, rsp_dst1, rsp_dst0} !== expv[v]) begin n_fail++; $display("[TB] FAIL arith_res[%0d]: got %h expected %h", v, {rsp_sat, rsp_dst1, rsp_dst0}, expv[v]); end
        end
        req_valid = 4'b0000;
        step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL arith_drain: got %0b expected 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 4'h0, 4'(i), 4'h0, 3'b000);
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_rdy = 4'(1 << (k % 4));
            n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, exp_rdy); end
            step();
            n_checks++; if ({rsp_valid, rsp_id, rsp_dst0} !== {1'b1, 2'(k % 4), 4'(k % 4)}) begin n_fail++; $display("[TB] FAIL rr_rsp[%0d]: got v=%0b id=%0d d0=%0d expected id=%0d", k, rsp_valid, rsp_id, rsp_dst0, k % 4); end
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_backpressure();
        set_req(0, 4'hA, 4'hB, 4'h0, 3'b000);
        set_req(1, 4'h0, 4'h1, 4'h0, 3'b000);
        set_req(3, 4'h0, 4'h3, 4'h0, 3'b000);
        req_valid = 4'b0001; rsp_ready = 1'b1;
        step();
        req_valid = 4'b1010; rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready); end
            n_checks++; if ({rsp_valid, rsp_id, rsp_dst1, rsp_dst0, rsp_sat} !== {1'b1, 2'd0, 8'hAB, 1'b0}) begin n_fail++; $display("[TB] FAIL bp_hold[%0d]: got v=%0b id=%0d d=%h%h s=%0b expected id=0 d=ab", c, rsp_valid, rsp_id, rsp_dst1, rsp_dst0, rsp_sat); end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL bp_release_ready: got %b expected 0010", req_ready); end
        step();
        n_checks++; if ({rsp_valid, rsp_id, rsp_dst0} !== {1'b1, 2'd1, 4'h1}) begin n_fail++; $display("[TB] FAIL bp_rsp1: got id=%0d d0=%0d expected id=1 d0=1", rsp_id, rsp_dst0); end
        req_valid = 4'b1000;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("[TB] FAIL bp_ready3: got %b expected 1000", req_ready); end
        step();
        n_checks++; if ({rsp_valid, rsp_id, rsp_dst0} !== {1'b1, 2'd3, 4'h3}) begin n_fail++; $display("[TB] FAIL bp_rsp3: got id=%0d d0=%0d expected id=3 d0=3", rsp_id, rsp_dst0); end
        req_valid = 4'b0000;
        step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_empty: got %0b expected 0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b1111; rsp_ready = 1'b1;
        step(); step();
        req_valid = 4'b0110; rst = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL midrst_ready: got %b expected 0000", req_ready); end
        step();
        n_checks++; if ({rsp_valid, rsp_id, rsp_dst1, rsp_dst0, rsp_sat} !== 12'd0) begin n_fail++; $display("[TB] FAIL midrst_rsp: got v=%0b id=%0d d=%h%h s=%0b expected all 0", rsp_valid, rsp_id, rsp_dst1, rsp_dst0, rsp_sat); end
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL midrst_first_grant: got %b expected 0010", req_ready); end
        step();
        n_checks++; if ({rsp_valid, rsp_id} !== 3'b101) begin n_fail++; $display("[TB] FAIL midrst_rsp_id: got v=%0b id=%0d expected v=1 id=1", rsp_valid, rsp_id); end
        req_valid = 4'b0000;
        step();
    endtask

`ifdef ADD8_ARB_STATS_EN
    task automatic test_stats();
        rst = 1'b1; step(); rst = 1'b0;
        n_checks++; if ({stat_sat_cnt, stat_op_cnt} !== 32'd0) begin n_fail++; $display("[TB] FAIL stats_rst: got %h expected 0", {stat_sat_cnt, stat_op_cnt}); end
        set_req(0, 4'hF, 4'hF, 4'h1, 3'b000);
        req_valid = 4'b0001; rsp_ready = 1'b1; stat_clr = 1'b1;
        step();
        n_checks++; if ({rsp_sat, stat_sat_cnt, stat_op_cnt} !== {1'b1, 32'd0}) begin n_fail++; $display("[TB] FAIL stats_clr: got sat=%0b sc=%0d oc=%0d expected sat=1 0 0", rsp_sat, stat_sat_cnt, stat_op_cnt); end
        stat_clr = 1'b0;
        step();
        req_valid = 4'b0000;
        step();
        n_checks++; if ({stat_sat_cnt, stat_op_cnt} !== {16'd1, 16'd1}) begin n_fail++; $display("[TB] FAIL stats_count: got sc=%0d oc=%0d expected 1 1", stat_sat_cnt, stat_op_cnt); end
    endtask
`endif

    initial begin
        $display("[TB] starting add8_arb bench");
        test_reset();
        test_arith();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
`ifdef ADD8_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
